// File: rtl/clkrst_pkg.sv
// Shared types and constants for the reset sequencer and its helpers.
package clkrst_pkg;

    // Sequencer states, in the order the domains are brought out of reset.
    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_MEM    = 3'd1,
        S_PERIPH = 3'd2,
        S_CORE   = 3'd3,
        S_RUN    = 3'd4,
        S_SOFT   = 3'd5
    } state_t;

    localparam int unsigned CAUSE_W   = 2;
    localparam int unsigned RST_CNT_W = 8;

    // Reset cause encoding; 2'b00 is never driven.
    typedef logic [CAUSE_W-1:0] cause_t;
    localparam cause_t CAUSE_EXT  = 2'b01;
    localparam cause_t CAUSE_SOFT = 2'b10;
    localparam cause_t CAUSE_HOLD = 2'b11;

    // Larger of two hold lengths, used to size the hold counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-release reset synchroniser.
//   clk    : destination clock
//   resetn : asynchronous active-low reset in
//   sync_n : active-low reset, released synchronously to clk
module reset_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    output logic sync_n
);

    logic [STAGES-1:0] sync_q;

    // Shift ones in after release; clearing is immediate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases memory, peripheral and core resets in order after a synchronised
// reset release, handles core soft-reset requests and an external hold, and
// records the last reset cause plus a saturating reset count.
//   clk, resetn        : clock and asynchronous active-low reset
//   ext_hold           : clock not stable; abort / hold sequencing
//   soft_rst_req       : soft-reset request from the core (honoured in S_RUN)
//   mem_resetn         : memory reset (active low)
//   periph_resetn      : peripheral reset (active low)
//   core_resetn        : core reset (active low)
//   seq_done           : high only in S_RUN
//   rst_cause          : last reset cause (01 ext, 10 soft, 11 hold)
//   rst_cnt            : soft + hold resets since async reset, saturating
module reset_sequencer
    import clkrst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MEM_HOLD    = 16,
    parameter int unsigned PERIPH_HOLD = 4,
    parameter int unsigned CORE_HOLD   = 8,
    parameter int unsigned SOFT_HOLD   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ext_hold,
    input  logic       soft_rst_req,
    output logic       mem_resetn,
    output logic       periph_resetn,
    output logic       core_resetn,
    output logic       seq_done,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_cnt
);

    localparam int unsigned MAX_HOLD = max_u(max_u(MEM_HOLD, PERIPH_HOLD),
                                             max_u(CORE_HOLD, SOFT_HOLD));
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD) + 1;

    localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_HOLD - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_HOLD - 1);

    logic                 sync_n;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    cause_t               cause_d;
    logic [RST_CNT_W-1:0] rst_cnt_d, rst_cnt_inc_c;
    logic                 mem_d, periph_d, core_d, done_d;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk    (clk),
        .resetn (resetn),
        .sync_n (sync_n)
    );

    // Saturating increment of the reset count.
    assign rst_cnt_inc_c = (rst_cnt == '1) ? rst_cnt : rst_cnt + RST_CNT_W'(1);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_SYNC;
            cnt_q         <= '0;
            rst_cause     <= CAUSE_EXT;
            rst_cnt       <= '0;
            mem_resetn    <= 1'b0;
            periph_resetn <= 1'b0;
            core_resetn   <= 1'b0;
            seq_done      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_cause     <= cause_d;
            rst_cnt       <= rst_cnt_d;
            mem_resetn    <= mem_d;
            periph_resetn <= periph_d;
            core_resetn   <= core_d;
            seq_done      <= done_d;
        end
    end

    // Next state, hold counter, cause/count and next outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = rst_cause;
        rst_cnt_d = rst_cnt;
        mem_d     = 1'b0;
        periph_d  = 1'b0;
        core_d    = 1'b0;
        done_d    = 1'b0;

        if (ext_hold) begin
            state_d = S_SYNC;
            cnt_d   = '0;
            if (state_q == S_RUN) begin
                cause_d   = CAUSE_HOLD;
                rst_cnt_d = rst_cnt_inc_c;
            end
        end else begin
            unique case (state_q)
                S_SYNC: begin
                    if (sync_n) begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                end
                S_MEM: begin
                    if (cnt_q == MEM_LAST) begin
                        state_d = S_PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PERIPH: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_d = S_CORE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CORE: begin
                    if (cnt_q == CORE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (soft_rst_req) begin
                        state_d   = S_SOFT;
                        cnt_d     = '0;
                        cause_d   = CAUSE_SOFT;
                        rst_cnt_d = rst_cnt_inc_c;
                    end
                end
                S_SOFT: begin
                    // Rejoin the sequence at the peripheral stage; memory stays up.
                    if (cnt_q == SOFT_LAST) begin
                        state_d = S_PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs follow the state being entered so they change on the same edge.
        unique case (state_d)
            S_PERIPH: mem_d = 1'b1;
            S_CORE: begin
                mem_d    = 1'b1;
                periph_d = 1'b1;
            end
            S_RUN: begin
                mem_d    = 1'b1;
                periph_d = 1'b1;
                core_d   = 1'b1;
                done_d   = 1'b1;
            end
            S_SOFT:  mem_d = 1'b1;
            default: mem_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

    logic       clk          = 1'b0;
    logic       resetn       = 1'b1;
    logic       ext_hold     = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       mem_resetn;
    logic       periph_resetn;
    logic       core_resetn;
    logic       seq_done;
    logic [1:0] rst_cause;
    logic [7:0] rst_cnt;

    int checks   = 0;
    int failures = 0;
    logic mem_ok;

    reset_sequencer u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .ext_hold      (ext_hold),
        .soft_rst_req  (soft_rst_req),
        .mem_resetn    (mem_resetn),
        .periph_resetn (periph_resetn),
        .core_resetn   (core_resetn),
        .seq_done      (seq_done),
        .rst_cause     (rst_cause),
        .rst_cnt       (rst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {mem, periph, core, seq_done}
    function automatic logic [31:0] outs();
        return {28'd0, mem_resetn, periph_resetn, core_resetn, seq_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges, checking outputs against the edge each release is due at.
    task automatic run_edges(input string tag, input int n, input int mem_e,
                             input int per_e, input int core_e);
        logic [3:0] x;
        for (int e = 1; e <= n; e++) begin
            step();
            x = {e >= mem_e, e >= per_e, e >= core_e, e >= core_e};
            check($sformatf("%s_e%0d", tag, e), outs(), {28'd0, x});
        end
    endtask

    initial begin
        // Power-on
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_outs", outs(), 32'h0);
        check("por_cause", 32'(rst_cause), 32'h1);
        check("por_cnt", 32'(rst_cnt), 32'h0);
        resetn = 1'b1;
        run_edges("por", 31, 19, 23, 31);
        check("por_end_cause", 32'(rst_cause), 32'h1);
        check("por_end_cnt", 32'(rst_cnt), 32'h0);

        // One-cycle soft reset
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("soft_e1_outs", outs(), 32'h8);
        check("soft_cause", 32'(rst_cause), 32'h2);
        check("soft_cnt", 32'(rst_cnt), 32'h1);
        run_edges("soft", 16, 0, 8, 16);

        // ext_hold and soft_rst_req together in S_RUN, then hold for 10 edges
        ext_hold     = 1'b1;
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("coll_outs", outs(), 32'h0);
        check("coll_cause", 32'(rst_cause), 32'h3);
        check("coll_cnt", 32'(rst_cnt), 32'h2);
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("coll_hold_%0d", i), outs(), 32'h0);
        end
        ext_hold = 1'b0;
        run_edges("coll_rel", 25, 17, 21, 29);
        check("coll_end_cnt", 32'(rst_cnt), 32'h2);
        check("coll_end_cause", 32'(rst_cause), 32'h3);

        // Async reset while in S_CORE, between edges
        #3 resetn = 1'b0;
        #1;
        check("async_outs", outs(), 32'h0);
        check("async_cnt", 32'(rst_cnt), 32'h0);
        check("async_cause", 32'(rst_cause), 32'h1);
        step();
        step();
        resetn = 1'b1;
        run_edges("rerun", 31, 19, 23, 31);

        // ext_hold high for 10 edges after reset release
        #3 resetn = 1'b0;
        step();
        ext_hold = 1'b1;
        resetn   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("exth_hold_%0d", i), outs(), 32'h0);
        end
        ext_hold = 1'b0;
        run_edges("exth", 29, 17, 21, 29);
        check("exth_cause", 32'(rst_cause), 32'h1);
        check("exth_cnt", 32'(rst_cnt), 32'h0);

        // soft_rst_req held high: one soft reset every 17 edges
        soft_rst_req = 1'b1;
        mem_ok       = 1'b1;
        for (int e = 1; e <= 5084; e++) begin
            step();
            mem_ok &= mem_resetn;
            if (e == 1)    check("sat_cnt_1", 32'(rst_cnt), 32'd1);
            if (e == 17)   check("sat_run_17", outs(), 32'hF);
            if (e == 18)   check("sat_cnt_18", 32'(rst_cnt), 32'd2);
            if (e == 4302) check("sat_cnt_254", 32'(rst_cnt), 32'd254);
            if (e == 4319) check("sat_cnt_255", 32'(rst_cnt), 32'd255);
            if (e == 5084) check("sat_cnt_300", 32'(rst_cnt), 32'd255);
        end
        soft_rst_req = 1'b0;
        check("sat_mem_held", 32'(mem_ok), 32'h1);
        check("sat_cause", 32'(rst_cause), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
